// File: rtl/cpu_mc_core.sv
// Multi-cycle 16-bit-instruction CPU core: FETCH/EXEC/MEM sequencer with req/ack
// handshakes to instruction and data memories, flags, retire counter and debug read.
module cpu_mc_core #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [15:0]       imem_rdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              halt,
   output logic [ADDR_W-1:0] pc_out,
   output logic [2:0]        flags_out,
   input  logic [2:0]        dbg_sel,
   output logic [DATA_W-1:0] dbg_data,
   output logic [CNT_W-1:0]  retired
);

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALTED} state_t;

   state_t                 state_q, state_d;
   logic [ADDR_W-1:0]      pc_q, pc_d, pc_inc;
   logic [15:0]            ir_q, ir_d;
   logic [7:0][DATA_W-1:0] regs_q, regs_d;
   logic [2:0]             flags_q, flags_d;
   logic [CNT_W-1:0]       retired_q, retired_d;
   logic                   halt_q, halt_d;
   logic                   imem_req_q, imem_req_d;
   logic                   dmem_req_q, dmem_req_d;
   logic                   dmem_we_q, dmem_we_d;
   logic [ADDR_W-1:0]      dmem_addr_q, dmem_addr_d;
   logic [DATA_W-1:0]      dmem_wdata_q, dmem_wdata_d;

   logic [3:0]        op;
   logic [2:0]        rd, rs1, rs2;
   logic [DATA_W-1:0] a, b, res, imm_data;
   logic [ADDR_W-1:0] imm_addr;
   logic [DATA_W:0]   sum, diff;
   logic              cout, set_flags, alu_wr;

   assign op       = ir_q[15:12];
   assign rd       = ir_q[11:9];
   assign rs1      = ir_q[8:6];
   assign rs2      = ir_q[5:3];
   assign imm_data = DATA_W'(ir_q[7:0]);
   assign imm_addr = ADDR_W'(ir_q[7:0]);
   assign a        = regs_q[rs1];
   assign b        = regs_q[rs2];
   // Extra top bit captures carry for ADD and borrow (rs1 < rs2) for SUB/CMP.
   assign sum      = {1'b0, a} + {1'b0, b};
   assign diff     = {1'b0, a} - {1'b0, b};
   assign pc_inc   = pc_q + ADDR_W'(1);

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ir_d         = ir_q;
      regs_d       = regs_q;
      flags_d      = flags_q;
      retired_d    = retired_q;
      halt_d       = halt_q;
      dmem_we_d    = dmem_we_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;
      res          = '0;
      cout         = 1'b0;
      set_flags    = 1'b0;
      alu_wr       = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (imem_req_q && imem_ack) begin
               ir_d    = imem_rdata;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d   = S_FETCH;
            pc_d      = pc_inc;
            retired_d = retired_q + CNT_W'(1);
            case (op)
               4'h1: begin res = sum[DATA_W-1:0];  cout = sum[DATA_W];  set_flags = 1'b1; alu_wr = 1'b1; end
               4'h2: begin res = diff[DATA_W-1:0]; cout = diff[DATA_W]; set_flags = 1'b1; alu_wr = 1'b1; end
               4'h3: begin res = a & b; set_flags = 1'b1; alu_wr = 1'b1; end
               4'h4: begin res = a | b; set_flags = 1'b1; alu_wr = 1'b1; end
               4'h5: begin res = a ^ b; set_flags = 1'b1; alu_wr = 1'b1; end
               4'h6: regs_d[rd] = imm_data;
               4'h7, 4'h8, 4'h9, 4'hA: begin
                  // Retire and PC advance are deferred to the data-ack edge.
                  state_d      = S_MEM;
                  pc_d         = pc_q;
                  retired_d    = retired_q;
                  dmem_addr_d  = (op == 4'h7 || op == 4'h8) ? imm_addr : ADDR_W'(a);
                  dmem_we_d    = (op == 4'h8 || op == 4'hA);
                  dmem_wdata_d = regs_q[rd];
               end
               4'hB: pc_d = imm_addr;
               4'hC: if (flags_q[0]) pc_d = imm_addr;
               4'hD: if (flags_q[1]) pc_d = imm_addr;
               4'hE: begin res = diff[DATA_W-1:0]; cout = diff[DATA_W]; set_flags = 1'b1; end
               4'hF: begin
                  pc_d    = pc_q;
                  halt_d  = 1'b1;
                  state_d = S_HALTED;
               end
               default: ;
            endcase
            if (set_flags) flags_d = {res[DATA_W-1], cout, res == '0};
            if (alu_wr) regs_d[rd] = res;
         end
         S_MEM: begin
            if (dmem_req_q && dmem_ack) begin
               if (!dmem_we_q) regs_d[rd] = dmem_rdata;
               dmem_we_d = 1'b0;
               pc_d      = pc_inc;
               retired_d = retired_q + CNT_W'(1);
               state_d   = S_FETCH;
            end
         end
         default: ;
      endcase
      // Requests are registered so they stay low through reset and rise the cycle after release.
      imem_req_d = (state_d == S_FETCH);
      dmem_req_d = (state_d == S_MEM);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_FETCH;
         pc_q         <= '0;
         ir_q         <= '0;
         regs_q       <= '0;
         flags_q      <= '0;
         retired_q    <= '0;
         halt_q       <= 1'b0;
         imem_req_q   <= 1'b0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ir_q         <= ir_d;
         regs_q       <= regs_d;
         flags_q      <= flags_d;
         retired_q    <= retired_d;
         halt_q       <= halt_d;
         imem_req_q   <= imem_req_d;
         dmem_req_q   <= dmem_req_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
      end
   end

   assign imem_req   = imem_req_q;
   assign imem_addr  = pc_q;
   assign dmem_req   = dmem_req_q;
   assign dmem_we    = dmem_we_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_wdata = dmem_wdata_q;
   assign halt       = halt_q;
   assign pc_out     = pc_q;
   assign flags_out  = flags_q;
   assign dbg_data   = regs_q[dbg_sel];
   assign retired    = retired_q;

endmodule

// File: tb/tb_cpu_mc_core.sv
// Scoreboard bench: retire and data-access expectations are queued by the stimulus
// and popped by monitors; a second instance covers ADDR_W=4 / DATA_W=16 wrap cases.
module tb_cpu_mc_core;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, rst_b, late_ack;
   logic        ia_req, ia_ack, da_req, da_we, da_ack, d_ack, a_halt;
   logic [7:0]  ia_addr, da_addr, da_wdata, da_rdata, a_pc, a_dbg;
   logic [15:0] ia_rdata, a_ret;
   logic [2:0]  a_fl, a_sel;

   logic        ib_req, ib_ack, db_req, db_we, db_ack, b_halt;
   logic [3:0]  ib_addr, db_addr, b_pc;
   logic [15:0] ib_rdata, db_wdata, db_rdata, b_dbg, b_ret;
   logic [2:0]  b_fl, b_sel;

   logic [15:0] imem_a [256];
   logic [7:0]  dmem_a [256];
   logic [15:0] imem_b [16];
   logic [15:0] dmem_b [16];
   int iwait, dwait, icnt, dcnt;

   int total = 0;
   int bad   = 0;

   typedef struct { int lat; int ret; int sel; int val; int pc; int fl; int hlt; } rexp_t;
   typedef struct { int addr; int we; int wdata; int run; } dexp_t;
   rexp_t q[$];
   dexp_t dq[$];
   int qb[$];

   cpu_mc_core #(.DATA_W(8), .ADDR_W(8), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .imem_req(ia_req), .imem_addr(ia_addr), .imem_ack(ia_ack), .imem_rdata(ia_rdata),
      .dmem_req(da_req), .dmem_we(da_we), .dmem_addr(da_addr), .dmem_wdata(da_wdata),
      .dmem_ack(da_ack), .dmem_rdata(da_rdata),
      .halt(a_halt), .pc_out(a_pc), .flags_out(a_fl), .dbg_sel(a_sel), .dbg_data(a_dbg),
      .retired(a_ret));

   cpu_mc_core #(.DATA_W(16), .ADDR_W(4), .CNT_W(16)) dut_b (
      .clk(clk), .rst_n(rst_b),
      .imem_req(ib_req), .imem_addr(ib_addr), .imem_ack(ib_ack), .imem_rdata(ib_rdata),
      .dmem_req(db_req), .dmem_we(db_we), .dmem_addr(db_addr), .dmem_wdata(db_wdata),
      .dmem_ack(db_ack), .dmem_rdata(db_rdata),
      .halt(b_halt), .pc_out(b_pc), .flags_out(b_fl), .dbg_sel(b_sel), .dbg_data(b_dbg),
      .retired(b_ret));

   // Zero-wait memories for the wide instance.
   assign ib_ack   = ib_req;
   assign ib_rdata = imem_b[ib_addr];
   assign db_ack   = db_req;
   assign db_rdata = dmem_b[db_addr];
   assign da_ack   = d_ack | late_ack;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Wait-state memory responder for instance A.
   initial begin
      ia_ack = 0; ia_rdata = 0; d_ack = 0; da_rdata = 0; icnt = 0; dcnt = 0;
      forever begin
         @(negedge clk);
         if (!rst_n || !ia_req) begin icnt = 0; ia_ack = 0; end
         else if (icnt >= iwait) begin ia_ack = 1; ia_rdata = imem_a[ia_addr]; icnt = 0; end
         else begin ia_ack = 0; icnt++; end
         if (!rst_n || !da_req) begin dcnt = 0; d_ack = 0; end
         else if (dcnt >= dwait) begin
            d_ack = 1; dcnt = 0;
            if (da_we) dmem_a[da_addr] = da_wdata;
            da_rdata = dmem_a[da_addr];
         end else begin d_ack = 0; dcnt++; end
      end
   end

   // Retire / data-access monitor for instance A.
   initial begin
      int cyc, last_cyc, run;
      logic [15:0] last_ret;
      rexp_t e;
      cyc = 0; last_cyc = 0; run = 0; last_ret = 0; a_sel = 0;
      forever begin
         @(negedge clk);
         #2;
         cyc++;
         if (rst_n && da_req) begin
            run++;
            if (dq.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_dmem_req: addr %0h", da_addr);
            end else begin
               chk("dmem_addr", da_addr, dq[0].addr);
               chk("dmem_we", da_we, dq[0].we);
               if (dq[0].we != 0) chk("dmem_wdata", da_wdata, dq[0].wdata);
               if (da_ack) begin
                  if (dq[0].run > 0) chk("dmem_req_cycles", run, dq[0].run);
                  void'(dq.pop_front());
               end
            end
         end
         if (!da_req || da_ack) run = 0;
         if (rst_n && a_ret != last_ret) begin
            if (q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_retire: retired %0d", a_ret);
            end else begin
               e = q.pop_front();
               chk("retired", a_ret, e.ret);
               chk("pc", a_pc, e.pc);
               chk("flags", a_fl, e.fl);
               chk("halt", a_halt, e.hlt);
               if (e.lat > 0) chk("latency", cyc - last_cyc, e.lat);
               a_sel = 3'(e.sel);
               #1;
               chk("reg", a_dbg, e.val);
            end
            last_cyc = cyc;
         end
         last_ret = a_ret;
      end
   end

   // Fetch-address monitor for instance B.
   initial begin
      int ea;
      forever begin
         @(negedge clk);
         #2;
         if (rst_b && ib_req && ib_ack && qb.size() > 0) begin
            ea = qb.pop_front();
            chk("b_fetch_addr", ib_addr, ea);
         end
      end
   end

   task automatic pr(input int lat, ret, sel, val, pc, fl, hlt);
      rexp_t e;
      e.lat = lat; e.ret = ret; e.sel = sel; e.val = val; e.pc = pc; e.fl = fl; e.hlt = hlt;
      q.push_back(e);
   endtask

   task automatic pd(input int addr, we, wdata, run);
      dexp_t e;
      e.addr = addr; e.we = we; e.wdata = wdata; e.run = run;
      dq.push_back(e);
   endtask

   task automatic hold_reset();
      @(negedge clk);
      rst_n = 0;
      q.delete();
      dq.delete();
      foreach (imem_a[i]) imem_a[i] = 16'h0;
      foreach (dmem_a[i]) dmem_a[i] = 8'h0;
      iwait = 0;
      dwait = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic wait_drain(input int maxc);
      int n = 0;
      while ((q.size() != 0 || dq.size() != 0) && n < maxc) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0 || dq.size() != 0) begin
         total++; bad++;
         $display("FAIL drain_timeout: %0d retire and %0d data expectations left", q.size(), dq.size());
      end
      @(negedge clk);
   endtask

   initial begin
      int n;
      rst_n = 0; rst_b = 0; late_ack = 0; b_sel = 0; iwait = 0; dwait = 0;
      foreach (imem_b[i]) imem_b[i] = 16'h0;
      foreach (dmem_b[i]) dmem_b[i] = 16'h0;
      hold_reset();
      #2;
      chk("rst_imem_req", ia_req, 0);
      chk("rst_dmem_req", da_req, 0);
      chk("rst_pc", a_pc, 0);
      chk("rst_retired", a_ret, 0);
      chk("rst_halt", a_halt, 0);
      chk("rst_flags", a_fl, 0);

      // ADD with carry out
      imem_a[0] = 16'h62F0; imem_a[1] = 16'h6420; imem_a[2] = 16'h1650; imem_a[3] = 16'hF000;
      pr(-1, 1, 1, 'hF0, 1, 0, 0);
      pr(2, 2, 2, 'h20, 2, 0, 0);
      pr(2, 3, 3, 'h10, 3, 3'b010, 0);
      pr(2, 4, 3, 'h10, 3, 3'b010, 1);
      release_reset();
      wait_drain(100);

      // CMP equal -> JZ taken; CMP less -> JZ falls through
      hold_reset();
      imem_a[0] = 16'h6205; imem_a[1] = 16'hE048; imem_a[2] = 16'hC010;
      imem_a[16] = 16'h6406; imem_a[17] = 16'hE050; imem_a[18] = 16'hC030; imem_a[19] = 16'hF000;
      pr(-1, 1, 1, 5, 1, 0, 0);
      pr(2, 2, 1, 5, 2, 3'b001, 0);
      pr(2, 3, 1, 5, 'h10, 3'b001, 0);
      pr(2, 4, 2, 6, 'h11, 3'b001, 0);
      pr(2, 5, 2, 6, 'h12, 3'b110, 0);
      pr(2, 6, 2, 6, 'h13, 3'b110, 0);
      pr(2, 7, 2, 6, 'h13, 3'b110, 1);
      release_reset();
      wait_drain(100);

      // Store then load with three data wait cycles
      hold_reset();
      dwait = 3;
      imem_a[0] = 16'h6AA5; imem_a[1] = 16'h8A40; imem_a[2] = 16'h7840; imem_a[3] = 16'hF000;
      pr(-1, 1, 5, 'hA5, 1, 0, 0);
      pr(6, 2, 5, 'hA5, 2, 0, 0);
      pr(6, 3, 4, 'hA5, 3, 0, 0);
      pr(2, 4, 4, 'hA5, 3, 0, 1);
      pd('h40, 1, 'hA5, 4);
      pd('h40, 0, 0, 4);
      release_reset();
      wait_drain(100);

      // Reset asserted during a pending store
      hold_reset();
      dwait = 10;
      imem_a[0] = 16'h6233; imem_a[1] = 16'h8250;
      pr(-1, 1, 1, 'h33, 1, 0, 0);
      pd('h50, 1, 'h33, -1);
      release_reset();
      n = 0;
      while (!da_req && n < 50) begin @(negedge clk); n++; end
      chk("store_req_seen", da_req, 1);
      repeat (2) @(negedge clk);
      rst_n = 0;
      #1;
      chk("rst_drops_req", da_req, 0);
      chk("rst_clears_retired", a_ret, 0);
      late_ack = 1;
      q.delete();
      dq.delete();
      imem_a[0] = 16'h6477; imem_a[1] = 16'hF000;
      dwait = 0;
      pr(-1, 1, 2, 'h77, 1, 0, 0);
      pr(2, 2, 1, 0, 1, 0, 1);
      @(negedge clk);
      #2;
      chk("rst_hold_req", da_req, 0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      #2;
      chk("first_fetch_req", ia_req, 1);
      chk("first_fetch_addr", ia_addr, 0);
      chk("late_ack_no_req", da_req, 0);
      late_ack = 0;
      wait_drain(100);
      chk("store_not_done", dmem_a[8'h50], 0);

      // HALT at 0x07 then freeze
      hold_reset();
      imem_a[7] = 16'hF000;
      for (int i = 0; i < 7; i++) pr((i == 0) ? -1 : 2, i + 1, 0, 0, i + 1, 0, 0);
      pr(2, 8, 0, 0, 7, 0, 1);
      release_reset();
      wait_drain(100);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #2;
         chk("halted_imem_req", ia_req, 0);
         chk("halted_retired", a_ret, 8);
      end
      chk("halted_pc", a_pc, 7);
      chk("halted_flag", a_halt, 1);

      // Narrow PC wrap and wide ADD overflow
      imem_b[0] = 16'h7200; imem_b[1] = 16'h6401; imem_b[2] = 16'h1650; imem_b[3] = 16'hB00F;
      imem_b[15] = 16'h0000;
      dmem_b[0] = 16'hFFFF;
      qb.push_back(0); qb.push_back(1); qb.push_back(2); qb.push_back(3);
      qb.push_back(15); qb.push_back(0);
      @(negedge clk);
      rst_b = 1;
      n = 0;
      while (qb.size() != 0 && n < 100) begin @(negedge clk); n++; end
      if (qb.size() != 0) begin
         total++; bad++;
         $display("FAIL b_fetch_timeout: %0d fetches missing", qb.size());
      end
      #2;
      chk("b_flags", b_fl, 3'b011);
      b_sel = 3;
      #1;
      chk("b_r3", b_dbg, 16'h0000);
      b_sel = 1;
      #1;
      chk("b_r1", b_dbg, 16'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
